// File: rtl/half_dense_pkg.sv
// ---------------------------------------------------------------------------
// half_dense_pkg : shared types, Q-format constants and saturation helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package half_dense_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HSIG  = 2'd2,
        ACT_LRELU = 2'd3
    } act_sel_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        MAC  = 3'd2,
        FIN  = 3'd3,
        OUT  = 3'd4
    } state_e;

    localparam logic signed [15:0] Q_ONE  = 16'sh0100;
    localparam logic signed [15:0] Q_HALF = 16'sh0080;
    localparam logic signed [15:0] Q_MAX  = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN  = 16'sh8000;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'(Q_MAX)) begin
            return Q_MAX;
        end else if (v < 64'(Q_MIN)) begin
            return Q_MIN;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/half_activation_unit.sv
// ---------------------------------------------------------------------------
// half_activation_unit : combinational activation (identity/ReLU/hsig/leaky)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module half_activation_unit
    import half_dense_pkg::*;
#(
    parameter logic signed [15:0] ONE  = Q_ONE,
    parameter logic signed [15:0] HALF = Q_HALF
) (
    input  logic signed [15:0] pre,
    input  act_sel_e           act,
    output logic signed [15:0] y
);

    logic signed [16:0] hs;

    always_comb begin
        hs = 17'(pre >>> 2) + 17'(HALF);
        y  = pre;
        case (act)
            ACT_ID:    y = pre;
            ACT_RELU:  y = (pre < 0) ? 16'sd0 : pre;
            ACT_HSIG: begin
                if (hs < 0) begin
                    y = 16'sd0;
                end else if (hs > 17'(ONE)) begin
                    y = ONE;
                end else begin
                    y = hs[15:0];
                end
            end
            ACT_LRELU: y = (pre < 0) ? (pre >>> 3) : pre;
            default:   y = pre;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/half_dense_layer_engine.sv
// ---------------------------------------------------------------------------
// half_dense_layer_engine : one dense layer y = act(W.x + b), Q-format 16-bit
// Optional sticky saturation flag output under HALF_DENSE_SAT_FLAG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module half_dense_layer_engine
    import half_dense_pkg::*;
#(
    parameter int IN_LEN    = 8,
    parameter int OUT_LEN   = 4,
    parameter int MULTS     = 2,
    parameter int FRAC_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load_w,
    input  logic                    load_b,
    input  logic [MULTS-1:0][15:0]  data_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MULTS-1:0][15:0]  x_in,
    input  logic [1:0]              act_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_data,
    output logic [(OUT_LEN > 1 ? $clog2(OUT_LEN) : 1)-1:0] out_index,
    output logic                    out_last
`ifdef HALF_DENSE_SAT_FLAG_EN
    ,output logic                   sat_flag
`endif
);

    localparam int W_DEPTH = OUT_LEN * IN_LEN;
    localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int X_AW    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int IDX_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int ACC_W   = 32 + $clog2(IN_LEN) + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam logic signed [15:0] ONE  = 16'(1 << FRAC_BITS);
    localparam logic signed [15:0] HALF = 16'(1 << (FRAC_BITS - 1));

    logic signed [15:0] w_mem [W_DEPTH];
    logic signed [15:0] b_mem [OUT_LEN];
    logic signed [15:0] x_mem [IN_LEN];

    state_e                   state, state_nx;
    act_sel_e                 act_q;
    logic                     live;
    logic [W_AW-1:0]          w_ptr;
    logic [IDX_W-1:0]         b_ptr;
    logic [X_AW-1:0]          x_ptr;
    logic [IDX_W-1:0]         neuron;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [31:0]       prod;
    logic [W_AW-1:0]          row_base;
    logic signed [SUM_W-1:0]  biased;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [15:0]       pre;
    logic signed [15:0]       act_y;
    logic                     is_idle, accept, wr_w, wr_b, last_beat, last_neuron;

    // live keeps in_ready low until the first clock after reset release
    assign is_idle     = (state == IDLE);
    assign in_ready    = live && (is_idle || state == RECV) && !load_w && !load_b;
    assign accept      = in_valid && in_ready;
    assign wr_w        = is_idle && load_w;
    assign wr_b        = is_idle && load_b && !load_w;
    assign last_beat   = (x_ptr == X_AW'(IN_LEN - MULTS));
    assign last_neuron = (neuron == IDX_W'(OUT_LEN - 1));
    assign row_base    = W_AW'(neuron) * W_AW'(IN_LEN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last_beat ? MAC : RECV;
            RECV:    if (accept && last_beat) state_nx = MAC;
            MAC:     if (last_beat) state_nx = FIN;
            FIN:     state_nx = OUT;
            OUT:     if (out_ready) state_nx = last_neuron ? IDLE : MAC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        mac_sum = '0;
        prod    = '0;
        for (int i = 0; i < MULTS; i++) begin
            prod    = x_mem[X_AW'(x_ptr + X_AW'(i))]
                    * w_mem[W_AW'(row_base + W_AW'(x_ptr) + W_AW'(i))];
            mac_sum = mac_sum + ACC_W'(prod);
        end
    end

    assign biased  = SUM_W'(acc) + (SUM_W'(b_mem[neuron]) <<< FRAC_BITS);
    assign shifted = biased >>> FRAC_BITS;
    assign pre     = sat16(64'(shifted));

    half_activation_unit #(
        .ONE  (ONE),
        .HALF (HALF)
    ) u_act (
        .pre (pre),
        .act (act_q),
        .y   (act_y)
    );

    // Storage is deliberately outside reset so weights survive an abort
    always_ff @(posedge clk) begin
        if (wr_w) begin
            for (int i = 0; i < MULTS; i++) begin
                w_mem[W_AW'(w_ptr + W_AW'(i))] <= data_in[i];
            end
        end
        if (wr_b) begin
            b_mem[b_ptr] <= data_in[0];
        end
        if (accept) begin
            for (int i = 0; i < MULTS; i++) begin
                x_mem[X_AW'(x_ptr + X_AW'(i))] <= x_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live      <= 1'b0;
            act_q     <= ACT_ID;
            w_ptr     <= '0;
            b_ptr     <= '0;
            x_ptr     <= '0;
            neuron    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (wr_w) begin
                w_ptr <= (w_ptr == W_AW'(W_DEPTH - MULTS)) ? '0 : w_ptr + W_AW'(MULTS);
            end
            if (wr_b) begin
                b_ptr <= (b_ptr == IDX_W'(OUT_LEN - 1)) ? '0 : b_ptr + IDX_W'(1);
            end
            if (accept) begin
                x_ptr <= last_beat ? '0 : x_ptr + X_AW'(MULTS);
                if (is_idle) begin
                    act_q <= act_sel_e'(act_sel);
                end
            end
            // x_ptr doubles as the column index while accumulating
            if (state == MAC) begin
                acc   <= ((x_ptr == '0) ? '0 : acc) + mac_sum;
                x_ptr <= last_beat ? '0 : x_ptr + X_AW'(MULTS);
            end
            if (state == FIN) begin
                out_valid <= 1'b1;
                out_data  <= act_y;
                out_index <= neuron;
                out_last  <= last_neuron;
            end
            if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
                neuron    <= last_neuron ? '0 : neuron + IDX_W'(1);
            end
        end
    end

`ifdef HALF_DENSE_SAT_FLAG_EN
    logic pre_sat;
    assign pre_sat = (64'(shifted) != 64'(pre));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_flag <= 1'b0;
        end else if (accept && is_idle) begin
            sat_flag <= 1'b0;
        end else if (state == FIN && pre_sat) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_half_dense_layer_engine.sv
// ---------------------------------------------------------------------------
// tb_half_dense_layer_engine : directed scoreboard bench for the dense layer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_half_dense_layer_engine;

    localparam int IN_LEN    = 4;
    localparam int OUT_LEN   = 2;
    localparam int MULTS     = 2;
    localparam int FRAC_BITS = 8;

    typedef struct packed {
        logic [15:0] data;
        logic [0:0]  idx;
        logic        last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   load_w = 1'b0;
    logic                   load_b = 1'b0;
    logic [MULTS-1:0][15:0] data_in = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [MULTS-1:0][15:0] x_in = '0;
    logic [1:0]             act_sel = 2'd0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [15:0]            out_data;
    logic [0:0]             out_index;
    logic                   out_last;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] wm [IN_LEN*OUT_LEN];
    logic signed [15:0] bm [OUT_LEN];
    logic signed [15:0] xm [IN_LEN];
    exp_t sb [$];

    always #5 clk = ~clk;

    half_dense_layer_engine #(
        .IN_LEN    (IN_LEN),
        .OUT_LEN   (OUT_LEN),
        .MULTS     (MULTS),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load_w    (load_w),
        .load_b    (load_b),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .act_sel   (act_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: wide integer dot product, floor shift, clamp, activation
    function automatic logic [15:0] model(input int j, input int act);
        longint a;
        longint p;
        int     y;
        a = 0;
        for (int k = 0; k < IN_LEN; k++) begin
            a += longint'(wm[j*IN_LEN+k]) * longint'(xm[k]);
        end
        a += longint'(bm[j]) <<< FRAC_BITS;
        p = a >>> FRAC_BITS;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        case (act)
            0: y = int'(p);
            1: y = (p < 0) ? 0 : int'(p);
            2: begin
                y = int'(p >>> 2) + (1 << (FRAC_BITS - 1));
                if (y < 0) y = 0;
                if (y > (1 << FRAC_BITS)) y = 1 << FRAC_BITS;
            end
            default: y = (p < 0) ? int'(p >>> 3) : int'(p);
        endcase
        return 16'(y);
    endfunction

    task automatic set_w(input int row, input logic [15:0] v);
        for (int k = 0; k < IN_LEN; k++) wm[row*IN_LEN+k] = v;
    endtask

    task automatic load_biases(input bit with_valid);
        for (int j = 0; j < OUT_LEN; j++) begin
            @(negedge clk);
            load_b     = 1'b1;
            data_in    = '0;
            data_in[0] = bm[j];
            in_valid   = with_valid;
            x_in       = {16'hDEAD, 16'hBEEF};
            #1 check("in_ready_load_b", in_ready, 0);
        end
        @(negedge clk);
        load_b   = 1'b0;
        in_valid = 1'b0;
    endtask

    // Beat 0 also raises load_b: the bias beat must be dropped
    task automatic load_weights();
        for (int b = 0; b < IN_LEN*OUT_LEN/MULTS; b++) begin
            @(negedge clk);
            load_w     = 1'b1;
            load_b     = (b == 0);
            data_in[0] = wm[b*MULTS];
            data_in[1] = wm[b*MULTS+1];
        end
        @(negedge clk);
        load_w = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic send_vector(input int act);
        for (int b = 0; b < IN_LEN/MULTS; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in[0]  = xm[b*MULTS];
            x_in[1]  = xm[b*MULTS+1];
            act_sel  = (b == 0) ? 2'(act) : ~2'(act);
            #1 check("in_ready_beat", in_ready, 1);
        end
    endtask

    task automatic run_vector(input int act, input int hold);
        exp_t e;
        int   lat;
        for (int j = 0; j < OUT_LEN; j++) begin
            sb.push_back('{data: model(j, act), idx: 1'(j), last: (j == OUT_LEN-1)});
        end
        send_vector(act);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        for (int j = 0; j < OUT_LEN; j++) begin
            while (out_valid !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("latency", lat, IN_LEN/MULTS + 2);
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_index", out_index, e.idx);
            check("out_last", out_last, e.last);
            if (j == 0) begin
                for (int h = 0; h < hold; h++) begin
                    load_w  = (h % 2 == 0);
                    load_b  = (h % 2 == 1);
                    data_in = {16'h5A5A, 16'hA5A5};
                    @(negedge clk);
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, e.data);
                    check("hold_index", out_index, e.idx);
                    check("hold_in_ready", in_ready, 0);
                end
                load_w = 1'b0;
                load_b = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            lat = 1;
        end
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Identity
        set_w(0, 16'h0100); set_w(1, 16'h0100);
        bm[0] = 16'h0080; bm[1] = 16'h0080;
        xm[0] = 16'h0100; xm[1] = 16'h0200; xm[2] = 16'h0300; xm[3] = 16'h0400;
        load_biases(1'b0);
        load_weights();
        run_vector(0, 0);

        // ReLU
        set_w(0, 16'hFF00); set_w(1, 16'h0100);
        bm[0] = 16'h0000; bm[1] = 16'h0000;
        load_biases(1'b1);
        load_weights();
        run_vector(1, 0);

        // Saturation both ways
        set_w(0, 16'h7F00); set_w(1, 16'h8100);
        for (int k = 0; k < IN_LEN; k++) xm[k] = 16'h7F00;
        load_weights();
        run_vector(0, 0);

        // Hard sigmoid through bias-only rows
        set_w(0, 16'h0000); set_w(1, 16'h0000);
        bm[0] = 16'h0000; bm[1] = 16'h0300;
        load_biases(1'b0);
        load_weights();
        run_vector(2, 0);
        bm[0] = 16'hFD00; bm[1] = 16'h0040;
        load_biases(1'b0);
        run_vector(2, 0);

        // Leaky ReLU
        bm[0] = 16'hF800; bm[1] = 16'h0200;
        load_biases(1'b1);
        run_vector(3, 0);

        // Backpressure with ignored loads
        set_w(0, 16'h0100); set_w(1, 16'h0100);
        bm[0] = 16'h0080; bm[1] = 16'h0080;
        xm[0] = 16'h0100; xm[1] = 16'h0200; xm[2] = 16'h0300; xm[3] = 16'h0400;
        load_biases(1'b0);
        load_weights();
        run_vector(0, 5);

        // Abort during MAC, then rerun without reloading
        send_vector(0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_index", out_index, 0);
        check("abort_out_last", out_last, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_output", out_valid, 0);
        run_vector(0, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/half_dense_layer_engine.md
Name: half_dense_layer_engine

Overview:
- Parametrised successor of the fixed single-layer predict block: one fully-connected layer computing y = act(W·x + b) in signed 16-bit fixed point.
- Weights and biases are held in internal storage. The input vector streams in MULTS words per beat; outputs stream out one neuron per handshake.
- The activation is selectable at run time. Instances chain layer to layer (out_* of one feeds in_* of the next through an external packer).

Parameters:
- IN_LEN, 8, input vector length; must be a multiple of MULTS.
- OUT_LEN, 4, neuron count (output vector length).
- MULTS, 2, multipliers per cycle; also words per load/input beat.
- FRAC_BITS, 8, fractional bits of the Q format (default Q8.8, 1.0 = 16'h0100).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- load_w  input  1  weight load beat: MULTS words, row-major
- load_b  input  1  bias load beat: word in data_in[0]
- data_in  input  16 x MULTS  load data
- in_valid  input  1  input-vector beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- x_in  input  16 x MULTS  input-vector words, element order ascending
- act_sel  input  2  0 identity, 1 ReLU, 2 hard sigmoid, 3 leaky ReLU
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accept
- out_data  output  16  activated neuron value
- out_index  output  clog2(OUT_LEN)  neuron number
- out_last  output  1  high with the final neuron

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, out_index=0, out_last=0.
  - FSM goes to IDLE; load pointers, x pointer and neuron counter go to 0.
  - Weight, bias and x storage are NOT reset; contents are retained.
- FSM states: IDLE, RECV, MAC, FIN, OUT.
  - IDLE to RECV on the first accepted input beat. act_sel is sampled on that beat and held for the whole vector.
  - RECV to MAC after IN_LEN/MULTS accepted beats.
  - MAC lasts IN_LEN/MULTS cycles. Each cycle: acc += sum of MULTS products x[k]*W[j][k], each product full 32-bit.
  - FIN (1 cycle): add bias, shift, saturate, apply activation, and register the result.
  - OUT: hold out_valid until out_ready. Then go to MAC for neuron j+1, or to IDLE after neuron OUT_LEN-1.
- Latency: first out_valid appears IN_LEN/MULTS+2 cycles after the last input beat is accepted. Each subsequent neuron follows IN_LEN/MULTS+2 cycles after the previous handshake.
- in_ready: 1 in IDLE/RECV while load_w=load_b=0; otherwise 0.
- Loads:
  - Accepted only in IDLE.
  - load_w writes MULTS words at w_ptr, then w_ptr += MULTS, wrapping to 0 after OUT_LEN*IN_LEN.
  - load_b writes at b_ptr, wrapping at OUT_LEN.
  - load_w and load_b together: load_w wins and the bias beat is dropped.
  - A load beat in the same cycle as in_valid: the load wins and the input beat is not accepted.
  - Loads outside IDLE are ignored.
- Arithmetic:
  - Accumulator width is 32+clog2(IN_LEN)+1 bits, signed.
  - pre = (acc + (bias << FRAC_BITS)) >>> FRAC_BITS, using an arithmetic shift (floor).
  - pre is saturated to [16'h8000, 16'h7FFF].
- Activation:
  - identity: y = pre.
  - ReLU: y = 0 when pre < 0, else pre.
  - hard sigmoid: y = clamp((pre >>> 2) + 0.5, 0, 1.0).
  - leaky ReLU: y = pre >>> 3 when pre < 0, else pre.
- Output handshake: out_data, out_index and out_last stay stable while out_valid && !out_ready.
- Reset mid-operation aborts the vector immediately with no partial output.

Optional Feature:
- Macro HALF_DENSE_SAT_FLAG_EN.
- Defined: adds output sat_flag (1 bit, reset 0). It goes high and sticky when any pre value saturates, and clears on a new vector's first accepted beat.
- Undefined: no port and no logic.

Decomposition:
- Package half_dense_pkg holds:
  - act_sel_e enum (ACT_ID, ACT_RELU, ACT_HSIG, ACT_LRELU);
  - the state_e FSM enum;
  - Q-format constants (Q_ONE, Q_HALF, Q_MAX, Q_MIN);
  - function sat16().
- One sub-module, half_activation_unit: pure combinational, pre plus act_sel giving y. Unit-tested on its own.

Test Plan:
- Test config for all scenarios: IN_LEN=4, OUT_LEN=2, MULTS=2.
- Identity: W all 16'h0100, b=16'h0080, x={0100,0200,0300,0400}, act_sel=0 -> two outputs 16'h0A80, index 0 then 1, out_last on index 1.
- ReLU: row0 all 16'hFF00, row1 all 16'h0100, b=0, x as above -> out 16'h0000 then 16'h0A00.
- Saturation with act_sel=0:
  - W all 16'h7F00, x all 16'h7F00 -> 16'h7FFF.
  - Row negated -> 16'h8000.
- Hard sigmoid (act_sel=2):
  - pre 0 -> 16'h0080;
  - pre 16'h0300 -> 16'h0100;
  - pre 16'hFD00 -> 16'h0000.
- Leaky ReLU (act_sel=3): pre 16'hF800 -> 16'hFF00.
- Backpressure and mid-vector reset:
  - Hold out_ready=0 for 5 cycles: data stable, in_ready=0, loads ignored.
  - rstn pulse during MAC: all outputs 0. Rerun without reloading: same results as before the reset.
